// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the set-associative
//               write-through cache: FSM state encoding, replacement-mode
//               constants, and address-field width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MEM_WR    = 3'd2,
        MEM_RD    = 3'd3,
        WAIT_FILL = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam int REPL_LFU_FIFO = 0;
    localparam int REPL_FIFO     = 1;

    // Index field width for a given number of sets (one word per line).
    function automatic int calc_index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag field width: everything above the index and the byte offset.
    function automatic int calc_tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : cache_victim_sel
// Description : Combinational victim selection for one cache set.
//               Lowest invalid way first; otherwise LFU with oldest-first
//               tie-break (lowest index on full tie), or pure FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int CNT_W     = 4,
    parameter int REPL_MODE = REPL_LFU_FIFO,
    parameter int AGE_W     = $clog2(WAYS),
    parameter int WAY_W     = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]       i_valid,
    input  logic [WAYS*CNT_W-1:0] i_freq,
    input  logic [WAYS*AGE_W-1:0] i_age,
    output logic [WAY_W-1:0]      o_victim
);

    logic             w_any_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_best_way;
    logic [CNT_W-1:0] w_best_freq;
    logic [AGE_W-1:0] w_best_age;
    logic [CNT_W-1:0] w_cur_freq;
    logic [AGE_W-1:0] w_cur_age;
    logic             w_better;

    // Scan the set: find the lowest invalid way and the best replacement candidate.
    always_comb begin
        w_any_inv   = 1'b0;
        w_inv_way   = '0;
        w_best_way  = '0;
        w_best_freq = i_freq[0 +: CNT_W];
        w_best_age  = i_age[0 +: AGE_W];
        w_cur_freq  = '0;
        w_cur_age   = '0;
        w_better    = 1'b0;

        // Descending scan so the lowest invalid index is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end

        // Strict comparisons keep the lower index when candidates are equal.
        for (int w = 1; w < WAYS; w++) begin
            w_cur_freq = i_freq[w*CNT_W +: CNT_W];
            w_cur_age  = i_age[w*AGE_W +: AGE_W];
            if (REPL_MODE == REPL_FIFO) begin
                w_better = (w_cur_age > w_best_age);
            end else begin
                w_better = (w_cur_freq < w_best_freq) ||
                           ((w_cur_freq == w_best_freq) && (w_cur_age > w_best_age));
            end
            if (w_better) begin
                w_best_way  = WAY_W'(w);
                w_best_freq = w_cur_freq;
                w_best_age  = w_cur_age;
            end
        end

        o_victim = w_any_inv ? w_inv_way : w_best_way;
    end

endmodule
`default_nettype wire

// File: rtl/set_assoc_wt_cache_p.sv
`default_nettype none
// ============================================================================
// Module      : set_assoc_wt_cache_p
// Description : Parametrised write-through set-associative cache with a
//               valid/ready memory port, registered CPU handshake, LFU/FIFO
//               replacement, optional write-allocate and hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module set_assoc_wt_cache_p
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SETS        = 4,
    parameter int WAYS        = 4,
    parameter int CNT_W       = 4,
    parameter int REPL_MODE   = REPL_LFU_FIFO,
    parameter int WRITE_ALLOC = 1,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam int INDEX_W = calc_index_w(SETS);
    localparam int TAG_W   = calc_tag_w(ADDR_W, SETS);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int AGE_W   = $clog2(WAYS);
    localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(WAYS - 1);
    localparam logic [CNT_W-1:0]  FREQ_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;
    logic [DATA_W-1:0] r_rdata;
    logic              r_resp_valid;
    logic [STAT_W-1:0] r_hit_count;
    logic [STAT_W-1:0] r_miss_count;

    logic              r_valid [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [CNT_W-1:0]  r_freq  [SETS][WAYS];
    logic [AGE_W-1:0]  r_age   [SETS][WAYS];

    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic [WAYS-1:0]       w_set_valid;
    logic [WAYS*CNT_W-1:0] w_set_freq;
    logic [WAYS*AGE_W-1:0] w_set_age;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_accept;
    logic                  w_do_fill;
    logic [DATA_W-1:0]     w_fill_data;
    logic                  w_unused_addr;

    assign w_index       = r_addr[INDEX_W+1:2];
    assign w_tag         = r_addr[ADDR_W-1:INDEX_W+2];
    assign w_unused_addr = ^r_addr[1:0];
    assign w_accept      = cpu_req_valid && cpu_req_ready;

    // A fill happens on a write-allocate miss in LOOKUP or on the read return.
    assign w_do_fill   = ((r_state == LOOKUP) && r_we && !w_hit && (WRITE_ALLOC != 0)) ||
                         ((r_state == WAIT_FILL) && mem_resp_valid);
    assign w_fill_data = (r_state == LOOKUP) ? r_wdata : mem_rdata;

    // Parallel tag compare over the indexed set, plus flattening for the victim picker.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_set_valid = '0;
        w_set_freq  = '0;
        w_set_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_set_valid[w]               = r_valid[w_index][w];
            w_set_freq[w*CNT_W +: CNT_W] = r_freq[w_index][w];
            w_set_age[w*AGE_W +: AGE_W]  = r_age[w_index][w];
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .WAYS      (WAYS),
        .CNT_W     (CNT_W),
        .REPL_MODE (REPL_MODE),
        .AGE_W     (AGE_W),
        .WAY_W     (WAY_W)
    ) u_victim_sel (
        .i_valid  (w_set_valid),
        .i_freq   (w_set_freq),
        .i_age    (w_set_age),
        .o_victim (w_victim)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one request at a time, memory handshake stalls the FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (cpu_req_valid) w_next = LOOKUP;
            LOOKUP: begin
                if (r_we)       w_next = MEM_WR;
                else if (w_hit) w_next = RESP;
                else            w_next = MEM_RD;
            end
            MEM_WR:    if (mem_req_ready) w_next = RESP;
            MEM_RD:    if (mem_req_ready) w_next = WAIT_FILL;
            WAIT_FILL: if (mem_resp_valid) w_next = RESP;
            RESP:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Port outputs; everything is forced low while reset is asserted.
    always_comb begin
        cpu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        cpu_resp_valid = 1'b0;
        cpu_resp_hit   = 1'b0;
        cpu_rdata      = '0;
        hit_count      = '0;
        miss_count     = '0;
        if (!reset) begin
            cpu_req_ready  = (r_state == IDLE);
            cpu_resp_valid = r_resp_valid;
            cpu_resp_hit   = r_resp_valid && r_hit;
            cpu_rdata      = r_resp_valid ? r_rdata : '0;
            hit_count      = r_hit_count;
            miss_count     = r_miss_count;
            if ((r_state == MEM_WR) || (r_state == MEM_RD)) begin
                mem_req_valid = 1'b1;
                mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
            end
            if (r_state == MEM_WR) begin
                mem_we    = 1'b1;
                mem_wdata = r_wdata;
            end
        end
    end

    // Request capture, lookup results, line updates, replacement state and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_hit        <= 1'b0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_freq[s][w]  <= '0;
                    r_age[s][w]   <= '0;
                end
            end
        end else begin
            r_resp_valid <= (r_state == RESP);

            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end

            if (r_state == LOOKUP) begin
                r_hit   <= w_hit;
                r_rdata <= (!r_we && w_hit) ? r_data[w_index][w_hit_way] : '0;
                if (w_hit) begin
                    if (r_hit_count != STAT_MAX) r_hit_count <= r_hit_count + 1'b1;
                    if (r_freq[w_index][w_hit_way] != FREQ_MAX) begin
                        r_freq[w_index][w_hit_way] <= r_freq[w_index][w_hit_way] + 1'b1;
                    end
                    if (r_we) r_data[w_index][w_hit_way] <= r_wdata;
                end else begin
                    if (r_miss_count != STAT_MAX) r_miss_count <= r_miss_count + 1'b1;
                end
            end

            if (w_do_fill) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_victim) begin
                        r_valid[w_index][w] <= 1'b1;
                        r_tag[w_index][w]   <= w_tag;
                        r_data[w_index][w]  <= w_fill_data;
                        r_freq[w_index][w]  <= CNT_W'(1);
                        r_age[w_index][w]   <= '0;
                    end else if (r_valid[w_index][w] && (r_age[w_index][w] != AGE_MAX)) begin
                        r_age[w_index][w] <= r_age[w_index][w] + 1'b1;
                    end
                end
            end

            if ((r_state == WAIT_FILL) && mem_resp_valid) begin
                r_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_wt_cache_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_assoc_wt_cache_p
// Description : Directed self-checking bench for set_assoc_wt_cache_p.
//               Three instances (default, pure FIFO, write-no-allocate)
//               share one memory model; sel picks the active instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_assoc_wt_cache_p;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset         = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic [31:0] cpu_addr      = '0;
    logic        cpu_we        = 1'b0;
    logic [31:0] cpu_wdata     = '0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata     = '0;
    logic [1:0]  sel           = 2'd0;

    logic [2:0]  d_req_valid, d_req_ready, d_resp_valid, d_resp_hit;
    logic [2:0]  d_mem_req_valid, d_mem_req_ready, d_mem_we, d_mem_resp_valid;
    logic [31:0] d_rdata [3];
    logic [31:0] d_mem_addr [3];
    logic [31:0] d_mem_wdata [3];
    logic [15:0] d_hit_cnt [3];
    logic [15:0] d_miss_cnt [3];

    // Only the selected instance sees requests and memory traffic.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            d_req_valid[k]      = cpu_req_valid && (sel == 2'(k));
            d_mem_req_ready[k]  = (sel == 2'(k));
            d_mem_resp_valid[k] = mem_resp_valid && (sel == 2'(k));
        end
    end

    logic        s_req_ready, s_resp_valid, s_resp_hit, s_mem_req_valid, s_mem_we;
    logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
    logic [15:0] s_hit_cnt, s_miss_cnt;
    assign s_req_ready     = d_req_ready[sel];
    assign s_resp_valid    = d_resp_valid[sel];
    assign s_resp_hit      = d_resp_hit[sel];
    assign s_mem_req_valid = d_mem_req_valid[sel];
    assign s_mem_we        = d_mem_we[sel];
    assign s_rdata         = d_rdata[sel];
    assign s_mem_addr      = d_mem_addr[sel];
    assign s_mem_wdata     = d_mem_wdata[sel];
    assign s_hit_cnt       = d_hit_cnt[sel];
    assign s_miss_cnt      = d_miss_cnt[sel];

    set_assoc_wt_cache_p u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_req_valid(d_req_valid[0]), .cpu_req_ready(d_req_ready[0]),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp_valid[0]), .cpu_resp_hit(d_resp_hit[0]), .cpu_rdata(d_rdata[0]),
        .mem_req_valid(d_mem_req_valid[0]), .mem_req_ready(d_mem_req_ready[0]),
        .mem_we(d_mem_we[0]), .mem_addr(d_mem_addr[0]), .mem_wdata(d_mem_wdata[0]),
        .mem_resp_valid(d_mem_resp_valid[0]), .mem_rdata(mem_rdata),
        .hit_count(d_hit_cnt[0]), .miss_count(d_miss_cnt[0])
    );

    set_assoc_wt_cache_p #(.REPL_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req_valid(d_req_valid[1]), .cpu_req_ready(d_req_ready[1]),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp_valid[1]), .cpu_resp_hit(d_resp_hit[1]), .cpu_rdata(d_rdata[1]),
        .mem_req_valid(d_mem_req_valid[1]), .mem_req_ready(d_mem_req_ready[1]),
        .mem_we(d_mem_we[1]), .mem_addr(d_mem_addr[1]), .mem_wdata(d_mem_wdata[1]),
        .mem_resp_valid(d_mem_resp_valid[1]), .mem_rdata(mem_rdata),
        .hit_count(d_hit_cnt[1]), .miss_count(d_miss_cnt[1])
    );

    set_assoc_wt_cache_p #(.WRITE_ALLOC(0)) u_dut2 (
        .clk(clk), .reset(reset),
        .cpu_req_valid(d_req_valid[2]), .cpu_req_ready(d_req_ready[2]),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp_valid[2]), .cpu_resp_hit(d_resp_hit[2]), .cpu_rdata(d_rdata[2]),
        .mem_req_valid(d_mem_req_valid[2]), .mem_req_ready(d_mem_req_ready[2]),
        .mem_we(d_mem_we[2]), .mem_addr(d_mem_addr[2]), .mem_wdata(d_mem_wdata[2]),
        .mem_resp_valid(d_mem_resp_valid[2]), .mem_rdata(mem_rdata),
        .hit_count(d_hit_cnt[2]), .miss_count(d_miss_cnt[2])
    );

    // Memory model: always ready, read data returned two cycles after acceptance.
    logic [31:0] mem_arr [256];
    int          mrd = 0;
    int          mwr = 0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] m_last_addr = '0;
    logic [31:0] m_last_wdata = '0;

    always @(negedge clk) begin
        if (mem_resp_valid) mem_resp_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_arr[pend_addr[9:2]];
            end
        end
        if (s_mem_req_valid) begin
            m_last_addr = s_mem_addr;
            if (s_mem_we) begin
                mwr++;
                m_last_wdata = s_mem_wdata;
                mem_arr[s_mem_addr[9:2]] = s_mem_wdata;
            end else begin
                mrd++;
                pend_addr = s_mem_addr;
                cnt       = 2;
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One CPU transaction; lat counts edges after the acceptance edge until the response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic hit, output logic [31:0] rd, output int lat,
                          output int drd, output int dwr);
        int rd0, wr0;
        logic got;
        @(negedge clk);
        for (int i = 0; i < 20 && !s_req_ready; i++) @(negedge clk);
        rd0 = mrd;
        wr0 = mwr;
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wd;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        got = 1'b0;
        hit = 1'b0;
        rd  = '0;
        lat = 0;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (s_resp_valid) begin
                got = 1'b1;
                lat = i;
                hit = s_resp_hit;
                rd  = s_rdata;
            end
        end
        drd = mrd - rd0;
        dwr = mwr - wr0;
        chk($sformatf("resp_seen_%h", addr), 32'(got), 32'd1);
    endtask

    logic        h;
    logic [31:0] d;
    int          lat, drd, dwr;
    logic        saw_resp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h5A00_0000 | 32'(i << 2);
        mem_arr[2] = 32'h1234_5678;

        // Scenario 1: cold miss then hit on 0x008.
        sel = 2'd0;
        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(s_req_ready), 32'd0);
        do_reset();
        #1;
        chk("ready_after_reset", 32'(s_req_ready), 32'd1);
        chk("hits_after_reset", 32'(s_hit_cnt), 32'd0);
        chk("miss_after_reset", 32'(s_miss_cnt), 32'd0);
        chk("resp_after_reset", 32'(s_resp_valid), 32'd0);
        do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
        chk("s1_miss_hit", 32'(h), 32'd0);
        chk("s1_miss_data", d, 32'h1234_5678);
        chk("s1_miss_mrd", 32'(drd), 32'd1);
        chk("s1_miss_addr", m_last_addr, 32'h008);
        do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
        chk("s1_hit_hit", 32'(h), 32'd1);
        chk("s1_hit_data", d, 32'h1234_5678);
        chk("s1_hit_nomem", 32'(drd + dwr), 32'd0);
        chk("s1_hit_latency", 32'(lat), 32'd2);

        // Scenario 2: write-through with allocate, then read hit.
        do_reset();
        do_req(1'b1, 32'h004, 32'hCAFE_BABE, h, d, lat, drd, dwr);
        chk("s2_wr_count", 32'(dwr), 32'd1);
        chk("s2_wr_noread", 32'(drd), 32'd0);
        chk("s2_wr_addr", m_last_addr, 32'h004);
        chk("s2_wr_data", m_last_wdata, 32'hCAFE_BABE);
        chk("s2_wr_hit", 32'(h), 32'd0);
        chk("s2_wr_rdata", d, 32'd0);
        do_req(1'b0, 32'h004, '0, h, d, lat, drd, dwr);
        chk("s2_rd_hit", 32'(h), 32'd1);
        chk("s2_rd_data", d, 32'hCAFE_BABE);
        chk("s2_rd_nomem", 32'(drd), 32'd0);
        chk("s2_miss_cnt", 32'(s_miss_cnt), 32'd1);
        chk("s2_hit_cnt", 32'(s_hit_cnt), 32'd1);

        // Scenarios 3 and 4: identical access history, LFU then FIFO replacement.
        for (int m = 0; m < 2; m++) begin
            sel = 2'(m);
            do_reset();
            do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
            do_req(1'b0, 32'h018, '0, h, d, lat, drd, dwr);
            do_req(1'b0, 32'h028, '0, h, d, lat, drd, dwr);
            do_req(1'b0, 32'h038, '0, h, d, lat, drd, dwr);
            for (int i = 0; i < 5; i++) do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
            for (int i = 0; i < 3; i++) do_req(1'b0, 32'h018, '0, h, d, lat, drd, dwr);
            do_req(1'b0, 32'h028, '0, h, d, lat, drd, dwr);
            do_req(1'b0, 32'h038, '0, h, d, lat, drd, dwr);
            chk($sformatf("s%0d_hit_cnt", m + 3), 32'(s_hit_cnt), 32'd10);
            chk($sformatf("s%0d_miss_cnt", m + 3), 32'(s_miss_cnt), 32'd4);
            do_req(1'b0, 32'hB48, '0, h, d, lat, drd, dwr);
            chk($sformatf("s%0d_b48_hit", m + 3), 32'(h), 32'd0);
            chk($sformatf("s%0d_b48_mrd", m + 3), 32'(drd), 32'd1);
            if (m == 0) begin
                do_req(1'b0, 32'h038, '0, h, d, lat, drd, dwr);
                chk("s3_038_hit", 32'(h), 32'd1);
                do_req(1'b0, 32'h028, '0, h, d, lat, drd, dwr);
                chk("s3_028_hit", 32'(h), 32'd0);
                do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
                chk("s3_008_hit", 32'(h), 32'd1);
                chk("s3_008_data", d, 32'h1234_5678);
            end else begin
                do_req(1'b0, 32'h008, '0, h, d, lat, drd, dwr);
                chk("s4_008_hit", 32'(h), 32'd0);
                chk("s4_008_mrd", 32'(drd), 32'd1);
            end
        end

        // Scenario 5: write-no-allocate.
        sel = 2'd2;
        do_reset();
        do_req(1'b1, 32'h00C, 32'hDEAD_BEEF, h, d, lat, drd, dwr);
        chk("s5_wr_count", 32'(dwr), 32'd1);
        chk("s5_wr_hit", 32'(h), 32'd0);
        do_req(1'b0, 32'h00C, '0, h, d, lat, drd, dwr);
        chk("s5_rd_hit", 32'(h), 32'd0);
        chk("s5_rd_mrd", 32'(drd), 32'd1);
        chk("s5_rd_data", d, 32'hDEAD_BEEF);

        // Scenario 6: reset while waiting for a fill; late return must be ignored.
        sel = 2'd0;
        do_reset();
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_we        = 1'b0;
        cpu_addr      = 32'h01C;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_mem_req_valid) break;
        end
        chk("s6_mem_rd_issued", 32'(s_mem_req_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("s6_ready_in_reset", 32'(s_req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_ready_after", 32'(s_req_ready), 32'd1);
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (s_resp_valid) saw_resp = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("s6_no_resp", 32'(saw_resp), 32'd0);
        chk("s6_hit_cnt", 32'(s_hit_cnt), 32'd0);
        chk("s6_miss_cnt", 32'(s_miss_cnt), 32'd0);
        do_req(1'b0, 32'h01C, '0, h, d, lat, drd, dwr);
        chk("s6_rd_hit", 32'(h), 32'd0);
        chk("s6_rd_mrd", 32'(drd), 32'd1);
        chk("s6_rd_data", d, 32'h5A00_001C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
